// File: rtl/neo_pixel_cmd_loader_if.sv
// neo_pixel_cmd_loader_if: host-side command channel (valid/ready) into the loader
interface neo_pixel_cmd_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_pixel;
    logic [23:0] cmd_grb;
    logic        cmd_show;
    modport master (output cmd_valid, cmd_pixel, cmd_grb, cmd_show, input cmd_ready);
    modport slave (input cmd_valid, cmd_pixel, cmd_grb, cmd_show, output cmd_ready);
endinterface

// File: rtl/neo_pixel_cmd_loader.sv
// neo_pixel_cmd_loader: buffers whole-pixel colour commands and expands them into per-channel loads and frame sends
module neo_pixel_cmd_loader #(
    parameter int NUM_PIXELS = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    neo_pixel_cmd_loader_if.slave  cmd,
    input  logic                   ready_to_load,
    input  logic                   ready_to_send,
    output logic [7:0]             color_level,
    output logic [1:0]             color_index,
    output logic [2:0]             pixel_index,
    output logic                   load_color,
    output logic                   send_it,
    output logic                   busy,
    output logic                   cmd_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, LD_R, LD_B, LD_G, SHOW, SHOW_WAIT} state_t;
    state_t        state, state_nx;
    logic [27:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          w_show;
    logic [2:0]    w_pixel;
    logic [23:0]   w_grb;
    logic [27:0]   head;
    logic          full, empty, push, pop, bad;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign empty = count == '0;
    assign cmd.cmd_ready = !full;
    assign push = cmd.cmd_valid && !full;
    assign pop = state == IDLE && !empty;
    assign head = mem[rd_ptr];
    assign bad = int'(head[26:24]) >= NUM_PIXELS;
    assign busy = state != IDLE || !empty;
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= {cmd.cmd_show, cmd.cmd_pixel, cmd.cmd_grb};
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            {w_show, w_pixel, w_grb} <= '0;
            cmd_error <= 1'b0;
        end else begin
            state <= state_nx;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) {w_show, w_pixel, w_grb} <= head;
            cmd_error <= pop && bad;
        end
    // A rejected pixel still honours its show request so the host's frame boundary is preserved.
    always_comb begin
        state_nx = state;
        load_color = 1'b0;
        send_it = 1'b0;
        color_level = '0;
        color_index = '0;
        pixel_index = '0;
        case (state)
            IDLE: if (pop) state_nx = bad ? (head[27] ? SHOW : IDLE) : LD_R;
            LD_R, LD_B, LD_G: begin
                pixel_index = w_pixel;
                load_color = ready_to_load;
                color_index = state == LD_R ? 2'd0 : state == LD_B ? 2'd1 : 2'd2;
                color_level = state == LD_R ? w_grb[15:8] : state == LD_B ? w_grb[7:0] : w_grb[23:16];
                if (ready_to_load)
                    state_nx = state == LD_R ? LD_B : state == LD_B ? LD_G : (w_show ? SHOW : IDLE);
            end
            SHOW: begin
                send_it = ready_to_send;
                if (ready_to_send) state_nx = SHOW_WAIT;
            end
            SHOW_WAIT: if (!ready_to_send) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_neo_pixel_cmd_loader.sv
// tb_neo_pixel_cmd_loader: table vectors, corner sequences and random traffic checked against an event-list model
module tb_neo_pixel_cmd_loader;
    localparam int NP = 5;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ready_to_load, ready_to_send;
    logic [7:0] color_level;
    logic [1:0] color_index;
    logic [2:0] pixel_index;
    logic load_color, send_it, busy, cmd_error;
    neo_pixel_cmd_loader_if bus();
    neo_pixel_cmd_loader #(.NUM_PIXELS(NP), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .cmd(bus),
        .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
        .color_level(color_level), .color_index(color_index), .pixel_index(pixel_index),
        .load_color(load_color), .send_it(send_it), .busy(busy), .cmd_error(cmd_error));
    always #10 clock = ~clock;
    int n_total = 0, n_bad = 0;
    int cyc = 0, sends_seen = 0, ctl_seen = 0, hold = 0, overlap = 0, idx3 = 0, obs_base = 0;
    logic rtl_low = 1'b0, rtl_rand = 1'b0, rts_en = 1'b1;
    int rts_drop = 1;
    logic [15:0] obs_q[$], exp_q[$];
    int obs_t[$];
    // Event word: {0, type[1:0], channel[1:0], pixel[2:0], level[7:0]}; type 1=load 2=send 3=error
    function automatic logic [15:0] ev(input logic [1:0] t, input logic [1:0] c, input logic [2:0] p, input logic [7:0] l);
        return {1'b0, t, c, p, l};
    endfunction
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (cmd_error) begin obs_q.push_back(ev(2'd3, 2'd0, 3'd0, 8'd0)); obs_t.push_back(cyc); end
            if (load_color) begin obs_q.push_back(ev(2'd1, color_index, pixel_index, color_level)); obs_t.push_back(cyc); end
            if (send_it) begin obs_q.push_back(ev(2'd2, 2'd0, 3'd0, 8'd0)); obs_t.push_back(cyc); sends_seen++; end
            if (load_color && send_it) overlap++;
            if (load_color && color_index == 2'd3) idx3++;
        end
    end
    // Controller stand-in: drops ready_to_send (and stalls loads) for rts_drop cycles after each send.
    initial begin
        logic sending;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (sends_seen != ctl_seen) begin ctl_seen = sends_seen; hold = rts_drop; end
            sending = hold != 0;
            ready_to_send = rts_en && !sending;
            ready_to_load = !rtl_low && !sending && (!rtl_rand || $urandom_range(0, 3) != 0);
            if (sending) hold--;
        end
    end
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(negedge clock);
        #1;
    endtask
    task automatic model(input logic [2:0] p, input logic [23:0] g, input logic s);
        if (int'(p) >= NP) exp_q.push_back(ev(2'd3, 2'd0, 3'd0, 8'd0));
        else begin
            exp_q.push_back(ev(2'd1, 2'd0, p, g[15:8]));
            exp_q.push_back(ev(2'd1, 2'd1, p, g[7:0]));
            exp_q.push_back(ev(2'd1, 2'd2, p, g[23:16]));
        end
        if (s) exp_q.push_back(ev(2'd2, 2'd0, 3'd0, 8'd0));
    endtask
    task automatic push(input logic [2:0] p, input logic [23:0] g, input logic s);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_pixel = p;
        bus.cmd_grb = g;
        bus.cmd_show = s;
        while (!bus.cmd_ready && n < 500) begin tick(); n++; end
        if (!bus.cmd_ready) begin
            n_total++;
            n_bad++;
            $display("FAIL push_timeout: cmd_ready=0 after %0d cycles, required 1", n);
        end
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        model(p, g, s);
    endtask
    task automatic wait_idle();
        int quiet, n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < 3000) begin tick(); quiet = busy ? 0 : quiet + 1; n++; end
        if (quiet < 4) begin
            n_total++;
            n_bad++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask
    task automatic wait_events(input int target);
        int n;
        n = 0;
        while (obs_q.size() < target && n < 500) begin tick(); n++; end
        if (obs_q.size() < target) begin
            n_total++;
            n_bad++;
            $display("FAIL event_timeout: events=%0d, required %0d", obs_q.size(), target);
        end
    endtask
    task automatic compare_model(input string name);
        check($sformatf("%s_count", name), obs_q.size() - obs_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
            check($sformatf("%s_ev%0d", name, i), obs_q[obs_base + i], exp_q[i]);
        obs_base = obs_q.size();
        exp_q.delete();
    endtask
    task automatic check_quiet(input string name);
        check({name, "_load"}, load_color, 0);
        check({name, "_send"}, send_it, 0);
        check({name, "_level"}, color_level, 0);
        check({name, "_index"}, color_index, 0);
        check({name, "_pixel"}, pixel_index, 0);
        check({name, "_error"}, cmd_error, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_ready"}, bus.cmd_ready, 1);
    endtask
    typedef struct {
        logic [2:0]  pix;
        logic [23:0] grb;
        logic        show;
        int          loads;
        logic [7:0]  r, b, g;
        int          errs, sends;
    } vec_t;
    vec_t vt[7];
    initial begin
        int b, nl, ne, ns, n_reset;
        logic [15:0] e;
        logic [2:0] rp;
        vt[0] = '{3'd2, 24'h102030, 1'b0, 3, 8'h20, 8'h30, 8'h10, 0, 0};
        vt[1] = '{3'd0, 24'hFFFFFF, 1'b1, 3, 8'hFF, 8'hFF, 8'hFF, 0, 1};
        vt[2] = '{3'd4, 24'h00AB00, 1'b0, 3, 8'hAB, 8'h00, 8'h00, 0, 0};
        vt[3] = '{3'd5, 24'h123456, 1'b0, 0, 8'h00, 8'h00, 8'h00, 1, 0};
        vt[4] = '{3'd6, 24'h654321, 1'b1, 0, 8'h00, 8'h00, 8'h00, 1, 1};
        vt[5] = '{3'd7, 24'hABCDEF, 1'b0, 0, 8'h00, 8'h00, 8'h00, 1, 0};
        vt[6] = '{3'd1, 24'hA55AC3, 1'b1, 3, 8'h5A, 8'hC3, 8'hA5, 0, 1};
        bus.cmd_valid = 1'b0;
        bus.cmd_pixel = '0;
        bus.cmd_grb = '0;
        bus.cmd_show = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            b = obs_q.size();
            nl = 0;
            ne = 0;
            ns = 0;
            push(vt[i].pix, vt[i].grb, vt[i].show);
            wait_idle();
            for (int k = b; k < obs_q.size(); k++) begin
                e = obs_q[k];
                if (e[14:13] == 2'd1) begin
                    check($sformatf("v%0d_level%0d", i, nl), e[7:0], nl == 0 ? vt[i].r : nl == 1 ? vt[i].b : vt[i].g);
                    check($sformatf("v%0d_index%0d", i, nl), e[12:11], nl);
                    check($sformatf("v%0d_pixel%0d", i, nl), e[10:8], vt[i].pix);
                    if (nl > 0) check($sformatf("v%0d_gap%0d", i, nl), obs_t[k] - obs_t[k-1], 1);
                    nl++;
                end
                ne += int'(e[14:13] == 2'd3);
                ns += int'(e[14:13] == 2'd2);
            end
            check($sformatf("v%0d_loads", i), nl, vt[i].loads);
            check($sformatf("v%0d_errors", i), ne, vt[i].errs);
            check($sformatf("v%0d_sends", i), ns, vt[i].sends);
            obs_base = obs_q.size();
            exp_q.delete();
        end
        check_quiet("idle");
        b = obs_q.size();
        push(3'd3, 24'h112233, 1'b0);
        wait_events(b + 1);
        rtl_low = 1'b1;
        nl = 0;
        ne = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            nl += int'(load_color);
            ne += int'(color_index != 2'd1);
        end
        check("stall_load_pulses", nl, 0);
        check("stall_index_held", ne, 0);
        check("stall_events", obs_q.size() - b, 1);
        rtl_low = 1'b0;
        wait_idle();
        compare_model("stall");
        for (int i = 0; i < 5; i++) push(3'(i), 24'($urandom), i == 4);
        wait_idle();
        compare_model("frame5");
        check("frame5_busy", busy, 0);
        rtl_low = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push(3'(i), 24'($urandom), 1'b0);
        check("full_ready", bus.cmd_ready, 0);
        repeat (3) tick();
        check("full_ready_hold", bus.cmd_ready, 0);
        check("full_busy", busy, 1);
        rtl_low = 1'b0;
        push(3'd3, 24'hC0FFEE, 1'b1);
        wait_idle();
        compare_model("fill");
        rts_en = 1'b0;
        tick();
        b = obs_q.size();
        push(3'd6, 24'h0F0F0F, 1'b1);
        repeat (6) tick();
        ne = 0;
        ns = 0;
        for (int k = b; k < obs_q.size(); k++) begin
            e = obs_q[k];
            ne += int'(e[14:13] == 2'd3);
            ns += int'(e[14:13] != 2'd3);
        end
        check("badpix_error", ne, 1);
        check("badpix_no_other", ns, 0);
        check("badpix_busy", busy, 1);
        rts_en = 1'b1;
        wait_idle();
        compare_model("badpix");
        b = obs_q.size();
        push(3'd2, 24'h445566, 1'b1);
        wait_events(b + 1);
        rtl_low = 1'b1;
        for (int i = 0; i < 3; i++) push(3'(i), 24'($urandom), 1'b1);
        tick();
        check("midld_index", color_index, 1);
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        n_reset = obs_q.size();
        repeat (2) tick();
        reset = 1'b0;
        rtl_low = 1'b0;
        repeat (40) tick();
        check("post_reset_events", obs_q.size() - n_reset, 0);
        check("post_reset_busy", busy, 0);
        obs_base = obs_q.size();
        exp_q.delete();
        rtl_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rts_drop = $urandom_range(1, 3);
            rp = 3'($urandom_range(0, 7));
            push(rp, 24'($urandom), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
        end
        wait_idle();
        rtl_rand = 1'b0;
        compare_model("random");
        check("load_send_overlap", overlap, 0);
        check("index_11_driven", idx3, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/neo_pixel_cmd_loader.md
Name: neo_pixel_cmd_loader

Overview:
- Upstream command front-end for the NeoPixel strand controller.
- Accepts whole-pixel colour commands ({G,R,B} plus pixel number) over a valid/ready interface and buffers them in a small FIFO.
- Expands each command into three single-channel load pulses (color_level / color_index / pixel_index / load_color) honouring the controller's ready_to_load.
- On request, issues send_it once ready_to_send is high, so a host can stream frames without tracking controller timing.

Parameters:
- NUM_PIXELS, 5: pixels on strand; pixel numbers >= NUM_PIXELS are rejected.
- FIFO_DEPTH, 4: command FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  system clock (50 MHz, same as controller).
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_pixel  in  3  target pixel number.
- cmd_grb  in  24  colour {G[23:16], R[15:8], B[7:0]}.
- cmd_show  in  1  after this command's loads, send the frame.
- ready_to_load  in  1  from controller.
- ready_to_send  in  1  from controller.
- color_level  out  8  channel value to controller.
- color_index  out  2  00 = red, 01 = blue, 10 = green; 11 never driven.
- pixel_index  out  3  pixel to controller.
- load_color  out  1  load strobe to controller.
- send_it  out  1  send strobe to controller.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- cmd_error  out  1  one-cycle pulse when a command is dropped for a bad pixel number.

Behaviour:
- Reset (async): FSM to IDLE, FIFO empty, working register cleared. Outputs: load_color = 0, send_it = 0, color_level = 0, color_index = 0, pixel_index = 0, cmd_error = 0, busy = 0, cmd_ready = 1. A reset mid-frame discards all queued and partial commands; no further strobes are issued.
- FIFO:
  - Entry is {show, pixel, grb}, 28 bits.
  - Push when cmd_valid && cmd_ready. Pop when FSM in IDLE && !empty.
  - Push and pop in the same cycle are both performed; count unchanged.
  - No push when full. Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, LD_R, LD_B, LD_G, SHOW, SHOW_WAIT.
- IDLE:
  - If !empty: pop the head into the working register.
  - If popped pixel >= NUM_PIXELS: cmd_error = 1 next cycle for exactly one cycle. Next state is SHOW if show = 1, else IDLE.
  - Otherwise next state is LD_R.
  - All strobes 0 in IDLE.
- LD_R / LD_B / LD_G:
  - pixel_index = working pixel.
  - color_index = 00 / 01 / 10; color_level = R / B / G respectively.
  - load_color = ready_to_load (combinational). If ready_to_load = 1, advance this cycle; otherwise hold state with load_color = 0.
  - LD_R -> LD_B -> LD_G. LD_G -> SHOW if show = 1, else IDLE.
  - Each accepted channel yields exactly one 1-cycle load_color pulse.
- SHOW:
  - send_it = ready_to_send. When ready_to_send = 1, send_it = 1 for that cycle and next state is SHOW_WAIT; otherwise hold.
  - load_color is never asserted together with send_it.
- SHOW_WAIT:
  - All strobes 0. Stay until ready_to_send = 0 is sampled (controller has entered SEND), then go to IDLE.
  - This prevents a duplicate send_it.
- Output fields (color_level / color_index / pixel_index) are 0 in IDLE, SHOW and SHOW_WAIT.
- Throughput: 3 cycles per good command plus 1 IDLE pop cycle when the controller is ready. Loads stall automatically while the controller is sending (ready_to_load = 0). Loads proceed during the controller's inter-frame wait.
- busy = (state != IDLE) || !empty.

Test Plan:
- Reset mid-LD_B with 3 queued commands -> all outputs 0 immediately; busy = 0, cmd_ready = 1; no load_color or send_it afterwards.
- Single command: pixel = 2, grb = 24'h10_20_30, show = 0, ready_to_load held 1 -> three consecutive load_color pulses: (idx 00, lvl 8'h20, pix 2), (01, 8'h30, 2), (10, 8'h10, 2); no send_it; busy drops after LD_G.
- ready_to_load held 0 for 7 cycles mid-LD_B -> outputs held (idx 01), load_color = 0 throughout; exactly one blue pulse once released.
- 5 commands for pixels 0–4, last with show = 1; ready_to_send drops 1 cycle after send_it -> 15 load pulses then exactly one send_it; FSM returns to IDLE.
- Push 6 commands back-to-back with FIFO_DEPTH = 4 and ready_to_load = 0 -> cmd_ready low after 5 accepted (4 in FIFO + 1 in working register); no commands lost, all loaded in order after release.
- Command pixel = 6, show = 1 -> one cmd_error pulse; no load_color; one send_it when ready_to_send = 1.
